// File: rtl/output_pack_if.sv
// CFU command port plus the upstream requantized-result stream for output_pack.
// valid/ready rule: a transfer happens on a rising edge where in_valid && in_ready; in_data must be held while in_valid && !in_ready.
interface output_pack_if #(
  parameter int INT32_SIZE = 32
);
  logic [6:0]                   cmd;
  logic [INT32_SIZE-1:0]        inp0;
  logic [INT32_SIZE-1:0]        inp1;
  logic [INT32_SIZE-1:0]        ret;
  logic                         output_buffer_valid;
  logic                         in_valid;
  logic signed [INT32_SIZE-1:0] in_data;
  logic                         in_ready;

  modport master (
    output cmd, inp0, inp1, in_valid, in_data,
    input  ret, output_buffer_valid, in_ready
  );

  modport slave (
    input  cmd, inp0, inp1, in_valid, in_data,
    output ret, output_buffer_valid, in_ready
  );
endinterface

// File: rtl/output_pack.sv
// Offset, clamp and pack four int8 results per 32-bit word into a FIFO drained by CFU commands.
// Define OUTPUT_PACK_SAT_COUNT_EN to add the clamp (saturation) counter read by command 7.
module output_pack #(
  parameter int INT32_SIZE = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  output_pack_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] CMD_CLEAR  = 7'd0;
  localparam logic [6:0] CMD_OFFSET = 7'd1;
  localparam logic [6:0] CMD_MIN    = 7'd2;
  localparam logic [6:0] CMD_MAX    = 7'd3;
  localparam logic [6:0] CMD_POP    = 7'd4;
  localparam logic [6:0] CMD_STATUS = 7'd5;
  localparam logic [6:0] CMD_FLUSH  = 7'd6;
  localparam logic [6:0] CMD_SAT    = 7'd7;

  logic [INT32_SIZE-1:0]      output_offset, act_min, act_max;
  logic                       s1_valid;
  logic signed [INT32_SIZE:0] s1_data;
  logic [1:0]                 lane;
  logic [INT32_SIZE-1:0]      pack, push_word, lane_word, sat_value;
  logic                       push_valid, flush_pending, accept, pop, sat_hit;
  logic [INT32_SIZE-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]              rd_ptr, wr_ptr;
  logic [CW-1:0]              count;
  logic signed [INT32_SIZE:0] min_ext, max_ext, lo_clamped, clamped;
  logic                       unused_inp0;

  assign unused_inp0             = ^bus.inp0;
  assign bus.output_buffer_valid = 1'b1;

  // Words already headed for the FIFO (S1 item + staged push) are reserved so the FIFO never overflows.
  assign bus.in_ready = !flush_pending &&
                        ((int'(count) + int'(push_valid) + int'(s1_valid)) <= (FIFO_DEPTH - 2));
  assign accept = bus.in_valid && bus.in_ready && (bus.cmd != CMD_CLEAR);
  assign pop    = (bus.cmd == CMD_POP) && (count != '0);

  always_comb begin
    min_ext    = {act_min[INT32_SIZE-1], act_min};
    max_ext    = {act_max[INT32_SIZE-1], act_max};
    lo_clamped = (s1_data < min_ext) ? min_ext : s1_data;
    clamped    = (lo_clamped > max_ext) ? max_ext : lo_clamped;
    sat_hit    = s1_valid && ((s1_data < min_ext) || (lo_clamped > max_ext));
    lane_word  = pack;
    lane_word[{lane, 3'b000} +: 8] = clamped[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      output_offset <= '0;
      act_min       <= '0;
      act_max       <= '0;
      s1_valid      <= 1'b0;
      s1_data       <= '0;
      lane          <= 2'd0;
      pack          <= '0;
      push_valid    <= 1'b0;
      push_word     <= '0;
      flush_pending <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      bus.ret       <= '0;
    end else if (bus.cmd == CMD_CLEAR) begin
      s1_valid      <= 1'b0;
      lane          <= 2'd0;
      pack          <= '0;
      push_valid    <= 1'b0;
      flush_pending <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      bus.ret       <= INT32_SIZE'(FIFO_DEPTH);
    end else begin
      case (bus.cmd)
        CMD_OFFSET: output_offset <= bus.inp1;
        CMD_MIN:    act_min       <= bus.inp1;
        CMD_MAX:    act_max       <= bus.inp1;
        CMD_POP:    bus.ret       <= pop ? mem[rd_ptr] : '0;
        CMD_STATUS: bus.ret       <= INT32_SIZE'({12'b0, flush_pending, lane, 1'b0, 16'(count)});
        CMD_FLUSH:  ;
        CMD_SAT:    bus.ret       <= sat_value;
        default:    bus.ret       <= '0;
      endcase

      s1_valid <= accept;
      if (accept) begin
        s1_data <= {bus.in_data[INT32_SIZE-1], bus.in_data} +
                   {output_offset[INT32_SIZE-1], output_offset};
      end

      push_valid <= 1'b0;
      if (s1_valid) begin
        lane <= lane + 2'd1;
        if (lane == 2'd3) begin
          push_valid <= 1'b1;
          push_word  <= lane_word;
          pack       <= '0;
        end else begin
          pack <= lane_word;
        end
      end else if (flush_pending && !push_valid) begin
        // Pipeline drained: emit whatever partial word is left.
        flush_pending <= 1'b0;
        if (lane != 2'd0) begin
          push_valid <= 1'b1;
          push_word  <= pack;
          pack       <= '0;
          lane       <= 2'd0;
        end
      end
      if (bus.cmd == CMD_FLUSH) flush_pending <= 1'b1;

      if (push_valid) wr_ptr <= wr_ptr + AW'(1);
      if (pop)        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_valid) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_valid) mem[wr_ptr] <= push_word;
  end

`ifdef OUTPUT_PACK_SAT_COUNT_EN
  logic [31:0] sat_count;

  always_ff @(posedge clk) begin
    if (reset || (bus.cmd == CMD_CLEAR)) begin
      sat_count <= '0;
    end else if (sat_hit && (sat_count != 32'hFFFF_FFFF)) begin
      sat_count <= sat_count + 32'd1;
    end
  end

  assign sat_value = INT32_SIZE'(sat_count);
`else
  logic unused_sat_hit;

  assign unused_sat_hit = sat_hit;
  assign sat_value      = '0;
`endif
endmodule

// File: tb/tb_output_pack.sv
// Directed bench for output_pack: vector table for the offset/clamp/pack path, hand sequences for
// flush, backpressure, FIFO wrap with simultaneous push/pop, and mid-stream clear.
module tb_output_pack;
  localparam int W     = 32;
  localparam int DEPTH = 16;

  localparam logic [6:0] C_CLEAR = 7'd0;
  localparam logic [6:0] C_OFF   = 7'd1;
  localparam logic [6:0] C_MIN   = 7'd2;
  localparam logic [6:0] C_MAX   = 7'd3;
  localparam logic [6:0] C_POP   = 7'd4;
  localparam logic [6:0] C_STAT  = 7'd5;
  localparam logic [6:0] C_FLUSH = 7'd6;
  localparam logic [6:0] C_SAT   = 7'd7;
  localparam logic [6:0] C_IDLE  = 7'd8;

  typedef struct {
    logic [31:0] offset;
    logic [31:0] act_min;
    logic [31:0] act_max;
    logic [31:0] d0, d1, d2, d3;
    logic [31:0] word;
    int          sat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   byte_ctr;
  logic [W-1:0] exp_q[$];
  vec_t vecs[5];

  output_pack_if #(.INT32_SIZE(W)) bus ();

  output_pack #(.INT32_SIZE(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic do_cmd(input logic [6:0] c, input logic [W-1:0] v);
    bus.cmd  = c;
    bus.inp1 = v;
    tick();
    bus.cmd  = C_IDLE;
    bus.inp1 = '0;
  endtask

  task automatic config_dp(input logic [W-1:0] off, input logic [W-1:0] mn, input logic [W-1:0] mx);
    do_cmd(C_OFF, off);
    do_cmd(C_MIN, mn);
    do_cmd(C_MAX, mx);
  endtask

  task automatic push(input logic [W-1:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, expected it to rise", n);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Feeds one word of in-range bytes (offset 0, full int8 range) and records it in the scoreboard.
  task automatic feed_word();
    logic [7:0] b [4];
    for (int j = 0; j < 4; j++) begin
      b[j] = 8'(byte_ctr);
      push(W'(byte_ctr));
      byte_ctr = (byte_ctr + 1) % 128;
    end
    exp_q.push_back({b[3], b[2], b[1], b[0]});
  endtask

  task automatic drain_check(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      do_cmd(C_POP, '0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s: got %08h with empty expected queue", name, bus.ret);
      end else begin
        check(name, bus.ret, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    int exp_sat;
    int idx;
    int max_occ;
    int cyc;
    logic acc;
    logic saw_stall;

    vecs[0] = '{32'd0,         -32'd128, 32'd127, 32'd1,         32'd2,         32'd3,         32'd4,         32'h04030201, 0};
    vecs[1] = '{32'd10,        -32'd128, 32'd127, 32'd200,       -32'd300,      32'd5,         -32'd20,       32'hF60F807F, 2};
    vecs[2] = '{-32'd5,        -32'd10,  32'd20,  32'd0,         32'd30,        -32'd100,      32'd12,        32'h07F614FB, 2};
    vecs[3] = '{32'd0,         32'd50,   32'd10,  32'd0,         32'd100,       -32'd100,      32'd10,        32'h0A0A0A0A, 4};
    vecs[4] = '{32'h7FFFFFFF,  -32'd128, 32'd127, 32'h7FFFFFFF,  32'h80000000,  32'd1,         32'h80000001,  32'h007FFF7F, 2};

    reset        = 1'b1;
    bus.cmd      = C_IDLE;
    bus.inp0     = '0;
    bus.inp1     = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    tick();
    check("obv_in_reset", W'(bus.output_buffer_valid), 1);
    tick();
    reset = 1'b0;
    check("reset_ret", bus.ret, 0);
    check("reset_in_ready", W'(bus.in_ready), 1);
    check("reset_obv", W'(bus.output_buffer_valid), 1);
    do_cmd(C_STAT, '0);
    check("reset_status", bus.ret, 0);
    do_cmd(C_POP, '0);
    check("reset_pop_empty", bus.ret, 0);
    do_cmd(C_SAT, '0);
    check("reset_sat", bus.ret, 0);

    // vector table: one packed word per entry, with exact push latency checked via status
    for (int i = 0; i < 5; i++) begin
      do_cmd(C_CLEAR, '0);
      check("vec_clear_ret", bus.ret, 32'd16);
      config_dp(vecs[i].offset, vecs[i].act_min, vecs[i].act_max);
      push(vecs[i].d0);
      push(vecs[i].d1);
      push(vecs[i].d2);
      push(vecs[i].d3);
      do_cmd(C_STAT, '0);
      check("vec_status_n1", bus.ret, 32'h00060000);
      do_cmd(C_STAT, '0);
      check("vec_status_n2", bus.ret, 32'h00000000);
      do_cmd(C_STAT, '0);
      check("vec_status_n3", bus.ret, 32'h00000001);
      do_cmd(C_POP, '0);
      check("vec_word", bus.ret, vecs[i].word);
      do_cmd(C_POP, '0);
      check("vec_pop_empty", bus.ret, 0);
      do_cmd(C_STAT, '0);
      check("vec_occ_after", bus.ret, 0);
`ifdef OUTPUT_PACK_SAT_COUNT_EN
      exp_sat = vecs[i].sat;
`else
      exp_sat = 0;
`endif
      do_cmd(C_SAT, '0);
      check("vec_sat", bus.ret, W'(exp_sat));
    end

    // flush of a two-lane partial word
    do_cmd(C_CLEAR, '0);
    config_dp(32'd0, -32'd128, 32'd127);
    push(32'd7);
    push(32'd8);
    do_cmd(C_FLUSH, '0);
    do_cmd(C_STAT, '0);
    check("flush_pending_status", bus.ret, 32'h000C0000);
    do_cmd(C_STAT, '0);
    check("flush_done_status", bus.ret, 32'h00000000);
    do_cmd(C_STAT, '0);
    check("flush_occ", bus.ret, 32'h00000001);
    do_cmd(C_POP, '0);
    check("flush_word", bus.ret, 32'h00000807);
    do_cmd(C_STAT, '0);
    check("flush_final_status", bus.ret, 0);

    // backpressure: hold in_valid with 64 bytes, no pops for 100 cycles, then pop every cycle
    do_cmd(C_CLEAR, '0);
    exp_q.delete();
    idx       = 0;
    max_occ   = 0;
    saw_stall = 1'b0;
    cyc       = 0;
    while (cyc < 2000 && !(idx == 64 && exp_q.size() == 0 && cyc >= 100)) begin
      bus.in_valid = (idx < 64);
      bus.in_data  = W'(idx);
      bus.cmd      = (cyc < 100) ? C_STAT : C_POP;
      acc          = bus.in_valid && bus.in_ready;
      if (bus.in_valid && !bus.in_ready) saw_stall = 1'b1;
      tick();
      if (acc) begin
        if (idx % 4 == 3) exp_q.push_back({8'(idx), 8'(idx - 1), 8'(idx - 2), 8'(idx - 3)});
        idx++;
      end
      if (cyc < 100) begin
        if (int'(bus.ret[15:0]) > max_occ) max_occ = int'(bus.ret[15:0]);
      end else if (bus.ret != '0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL bp_extra_word: got %08h with empty expected queue", bus.ret);
        end else begin
          check("bp_word", bus.ret, exp_q.pop_front());
        end
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.cmd      = C_IDLE;
    check("bp_all_accepted", W'(idx), 64);
    check("bp_drained", W'(exp_q.size()), 0);
    check("bp_stall_seen", W'(saw_stall), 1);
    check("bp_max_occ_le_depth", W'(max_occ <= DEPTH), 1);

    // wrap: 12 in, 8 out, 10 in (write pointer wraps), then push and pop on the same edge
    do_cmd(C_CLEAR, '0);
    exp_q.delete();
    byte_ctr = 1;
    for (int k = 0; k < 12; k++) feed_word();
    repeat (3) tick();
    drain_check("wrap_first", 8);
    for (int k = 0; k < 10; k++) feed_word();
    repeat (3) tick();
    do_cmd(C_STAT, '0);
    check("wrap_occ_before", bus.ret, 32'd14);
    feed_word();
    tick();
    do_cmd(C_POP, '0);
    check("same_edge_pop_head", bus.ret, exp_q.pop_front());
    do_cmd(C_STAT, '0);
    check("same_edge_occ", bus.ret, 32'd14);
    drain_check("wrap_order", 14);
    do_cmd(C_STAT, '0);
    check("wrap_empty", bus.ret, 0);

    // clear mid-stream after 6 inputs, with a transfer offered on the clear cycle
    do_cmd(C_CLEAR, '0);
    config_dp(32'd0, -32'd128, 32'd127);
    for (int k = 1; k <= 6; k++) push(W'(k));
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd99;
    do_cmd(C_CLEAR, '0);
    bus.in_valid = 1'b0;
    check("mid_clear_ret", bus.ret, 32'd16);
    do_cmd(C_STAT, '0);
    check("mid_clear_status", bus.ret, 0);
    push(32'h11);
    push(32'h22);
    push(32'h33);
    push(32'h44);
    repeat (3) tick();
    do_cmd(C_POP, '0);
    check("mid_clear_fresh_word", bus.ret, 32'h44332211);
    do_cmd(C_POP, '0);
    check("mid_clear_then_empty", bus.ret, 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
